// File: rtl/scratch_pad_streamer_pkg.sv
// Shared types and constants for the scratch pad streamer: FSM state
// encoding and the log2 helper used to size credit and FIFO counters.
package scratch_pad_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Ceiling log2; value 1 maps to 0.
  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Counter width able to hold 0..max_outstanding inclusive.
  function automatic int credit_width(input int max_outstanding);
    return log2_ceil(max_outstanding) + 1;
  endfunction

  localparam int DEFAULT_MAX_OUTSTANDING = 32;
  localparam int DEFAULT_CREDIT_WIDTH    = credit_width(DEFAULT_MAX_OUTSTANDING);

endpackage

// File: rtl/scratch_pad_streamer_if.sv
// Bundle of command, write stream, read stream and scratch pad port signals.
// slave is the streamer's view, master is the surrounding environment.
interface scratch_pad_streamer_if #(
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 12
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_base;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  done;

  logic                  wr_data_valid;
  logic                  wr_data_ready;
  logic [WIDTH-1:0]      wr_data;

  logic                  rd_data_valid;
  logic                  rd_data_ready;
  logic [WIDTH-1:0]      rd_data;

  logic                  sp_rd_en;
  logic                  sp_wr_en;
  logic [ADDR_WIDTH-1:0] sp_addr;
  logic [WIDTH-1:0]      sp_d;
  logic                  sp_full;
  logic [WIDTH-1:0]      sp_q;
  logic                  sp_valid;
  logic                  sp_stall;

  modport slave (
    input  cmd_valid, cmd_write, cmd_base, cmd_len,
    output cmd_ready, done,
    input  wr_data_valid, wr_data,
    output wr_data_ready,
    output rd_data_valid, rd_data,
    input  rd_data_ready,
    output sp_rd_en, sp_wr_en, sp_addr, sp_d, sp_stall,
    input  sp_full, sp_q, sp_valid
  );

  modport master (
    output cmd_valid, cmd_write, cmd_base, cmd_len,
    input  cmd_ready, done,
    output wr_data_valid, wr_data,
    input  wr_data_ready,
    input  rd_data_valid, rd_data,
    output rd_data_ready,
    input  sp_rd_en, sp_wr_en, sp_addr, sp_d, sp_stall,
    output sp_full, sp_q, sp_valid
  );

endinterface

// File: rtl/scratch_pad_streamer_resp_fifo.sv
// Synchronous response FIFO with a combinational head. A push into an empty
// FIFO shows on head the following cycle; push and pop together are lossless
// even when full.
module streamer_resp_fifo
  import scratch_pad_streamer_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32  // power of two, at least 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int PTR_W = log2_ceil(DEPTH);
  typedef logic [PTR_W:0]   count_t;
  typedef logic [PTR_W-1:0] ptr_t;
  localparam count_t FULL_COUNT = count_t'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  count_t           count;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Store pushed words.
  // NOTE: the storage array has no reset; the pointers and count alone say
  // which entries are live, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Advance pointers and occupancy.
  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values, so ordering inside the block does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + count_t'(1);
        2'b01:   count <= count - count_t'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scratch_pad_streamer.sv
// Streams read or write bursts between a single scratch pad port and
// valid/ready word streams. Reads are credit limited so responses always
// fit in the local FIFO.
module scratch_pad_streamer
  import scratch_pad_streamer_pkg::*;
#(
  parameter int WIDTH           = 64,
  parameter int ADDR_WIDTH      = 12,
  parameter int LEN_WIDTH       = 12,
  parameter int MAX_OUTSTANDING = 32
) (
  input logic                   clk,
  input logic                   rst,
  scratch_pad_streamer_if.slave bus
);

  localparam int CREDIT_W = credit_width(MAX_OUTSTANDING);
  typedef logic [CREDIT_W-1:0]   credit_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [LEN_WIDTH-1:0]  len_t;
  localparam credit_t CREDIT_MAX = credit_t'(MAX_OUTSTANDING);

  state_e     state;
  addr_t      addr;
  len_t       remaining;
  credit_t    credits;    // MAX_OUTSTANDING - (in_flight + FIFO occupancy)
  credit_t    in_flight;  // reads issued whose data has not come back yet
  logic       done_q;

  logic       rd_issue;
  logic       wr_issue;
  logic       resp_push;
  logic       resp_pop;
  logic       fifo_empty;
  logic [WIDTH-1:0] fifo_head;

  assign rd_issue  = (state == ST_READ) && (remaining != '0) && !bus.sp_full && (credits != '0);
  assign bus.wr_data_ready = (state == ST_WRITE) && (remaining != '0) && !bus.sp_full;
  assign wr_issue  = bus.wr_data_valid && bus.wr_data_ready;
  // Responses only matter while a read burst is active or draining.
  assign resp_push = bus.sp_valid && ((state == ST_READ) || (state == ST_DRAIN));
  assign resp_pop  = bus.rd_data_valid && bus.rd_data_ready;

  assign bus.cmd_ready     = (state == ST_IDLE);
  assign bus.done          = done_q;
  assign bus.sp_rd_en      = rd_issue;
  assign bus.sp_wr_en      = wr_issue;
  assign bus.sp_addr       = addr;
  assign bus.sp_d          = bus.wr_data;
  assign bus.sp_stall      = 1'b0;
  assign bus.rd_data_valid = !fifo_empty;
  assign bus.rd_data       = fifo_head;

  // Burst sequencing: command accept, address/length stepping, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            addr      <= bus.cmd_base;
            remaining <= bus.cmd_len;
            if (bus.cmd_len == '0)  done_q <= 1'b1;
            else if (bus.cmd_write) state  <= ST_WRITE;
            else                    state  <= ST_READ;
          end
        end
        ST_READ: begin
          if (rd_issue) begin
            addr      <= addr + addr_t'(1);
            remaining <= remaining - len_t'(1);
            if (remaining == len_t'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((in_flight == '0) && fifo_empty) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (wr_issue) begin
            addr      <= addr + addr_t'(1);
            remaining <= remaining - len_t'(1);
            if (remaining == len_t'(1)) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Credit and in-flight bookkeeping for read issue throttling.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits   <= CREDIT_MAX;
      in_flight <= '0;
    end else begin
      case ({rd_issue, resp_pop})
        2'b10:   credits <= credits - credit_t'(1);
        2'b01:   credits <= credits + credit_t'(1);
        default: credits <= credits;
      endcase
      case ({rd_issue, resp_push})
        2'b10:   in_flight <= in_flight + credit_t'(1);
        2'b01:   in_flight <= in_flight - credit_t'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  streamer_resp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_push),
    .push_data (bus.sp_q),
    .pop       (resp_pop),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_scratch_pad_streamer.sv
// Directed bench for scratch_pad_streamer with a fixed-latency scratch pad
// model that returns the read address as data six cycles after issue.
module tb_scratch_pad_streamer;

  localparam int WIDTH      = 64;
  localparam int ADDR_WIDTH = 12;
  localparam int LEN_WIDTH  = 12;
  localparam int MAX_OUT    = 32;
  localparam int SP_LAT     = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scratch_pad_streamer_if #(
    .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)
  ) bus ();

  scratch_pad_streamer #(
    .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Scratch pad read model: fixed latency, data equals address.
  logic [SP_LAT-1:0]     pipe_v = '0;
  logic [ADDR_WIDTH-1:0] pipe_a [SP_LAT];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v    <= {pipe_v[SP_LAT-2:0], bus.sp_rd_en};
      pipe_a[0] <= bus.sp_addr;
      for (int i = 1; i < SP_LAT; i++) pipe_a[i] <= pipe_a[i-1];
    end
  end
  assign bus.sp_valid = pipe_v[SP_LAT-1];
  assign bus.sp_q     = WIDTH'(pipe_a[SP_LAT-1]);

  // Event log sampled mid-cycle.
  int rd_addr_q[$], rd_cyc_q[$], wr_addr_q[$], wr_d_q[$], wr_cyc_q[$], got_q[$];
  int done_cnt = 0, done_cyc = 0, full_issue_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sp_rd_en === 1'b1) begin
        rd_addr_q.push_back(int'(bus.sp_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (bus.sp_wr_en === 1'b1) begin
        wr_addr_q.push_back(int'(bus.sp_addr));
        wr_d_q.push_back(int'(bus.sp_d));
        wr_cyc_q.push_back(cyc);
      end
      if (bus.rd_data_valid === 1'b1 && bus.rd_data_ready === 1'b1) got_q.push_back(int'(bus.rd_data));
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.sp_rd_en === 1'b1 && bus.sp_full === 1'b1) full_issue_cnt++;
      if (bus.sp_rd_en === 1'b1 && bus.sp_wr_en === 1'b1) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one command while idle; returns 1ns into the first cycle after accept.
  task automatic send_cmd(input logic write, input int base, input int len);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = write;
    bus.cmd_base  = ADDR_WIDTH'(base);
    bus.cmd_len   = LEN_WIDTH'(len);
    @(negedge clk);
    check("cmd_ready_at_accept", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1;
    end
    check(tag, seen, 1);
  endtask

  int r0, g0, d0, w0, f0, bad;

  initial begin
    bus.cmd_valid     = 1'b0;
    bus.cmd_write     = 1'b0;
    bus.cmd_base      = '0;
    bus.cmd_len       = '0;
    bus.wr_data_valid = 1'b0;
    bus.wr_data       = '0;
    bus.rd_data_ready = 1'b0;
    bus.sp_full       = 1'b0;

    // ---- reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_sp_rd_en", bus.sp_rd_en, 0);
    check("rst_sp_wr_en", bus.sp_wr_en, 0);
    check("rst_sp_stall", bus.sp_stall, 0);
    check("rst_wr_data_ready", bus.wr_data_ready, 0);
    check("rst_rd_data_valid", bus.rd_data_valid, 0);
    check("rst_credits", dut.credits, 32);
    check("rst_addr", dut.addr, 0);
    check("rst_remaining", dut.remaining, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- read burst base=10 len=4
    bus.rd_data_ready = 1'b1;
    r0 = rd_addr_q.size(); g0 = got_q.size(); d0 = done_cnt;
    send_cmd(1'b0, 10, 4);
    wait_done("rd4_done_seen", 40);
    settle(3);
    check("rd4_issue_count", rd_addr_q.size() - r0, 4);
    if (rd_addr_q.size() - r0 == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("rd4_addr%0d", i), rd_addr_q[r0+i], 10 + i);
      check("rd4_consecutive", rd_cyc_q[r0+3] - rd_cyc_q[r0], 3);
    end
    check("rd4_got_count", got_q.size() - g0, 4);
    if (got_q.size() - g0 == 4)
      for (int i = 0; i < 4; i++) check($sformatf("rd4_data%0d", i), got_q[g0+i], 10 + i);
    check("rd4_done_pulses", done_cnt - d0, 1);

    // ---- credit limit: len=40 with the read stream stalled
    bus.rd_data_ready = 1'b0;
    r0 = rd_addr_q.size(); g0 = got_q.size(); d0 = done_cnt;
    send_cmd(1'b0, 100, 40);
    settle(60);
    check("credit_issue_capped", rd_addr_q.size() - r0, 32);
    check("credit_exhausted", dut.credits, 0);
    check("credit_head_valid", bus.rd_data_valid, 1);
    check("credit_head_data", bus.rd_data, 100);
    settle(20);
    check("credit_no_more_issue", rd_addr_q.size() - r0, 32);
    bus.rd_data_ready = 1'b1;
    wait_done("credit_done_seen", 300);
    settle(3);
    check("credit_issue_total", rd_addr_q.size() - r0, 40);
    check("credit_got_count", got_q.size() - g0, 40);
    bad = 0;
    if (got_q.size() - g0 == 40)
      for (int i = 0; i < 40; i++) if (got_q[g0+i] != 100 + i) bad++;
    check("credit_data_order_errors", bad, 0);
    check("credit_done_pulses", done_cnt - d0, 1);
    check("credit_restored", dut.credits, 32);

    // ---- write burst with address wrap
    w0 = wr_addr_q.size(); r0 = rd_addr_q.size(); d0 = done_cnt;
    bus.wr_data_valid = 1'b1;
    bus.wr_data       = WIDTH'(1);
    send_cmd(1'b1, 4094, 4);
    begin
      int k;
      logic hs;
      k = 1;
      for (int i = 0; i < 50 && k <= 4; i++) begin
        @(negedge clk);
        hs = bus.wr_data_ready;
        @(posedge clk); #1;
        if (hs) begin
          k++;
          if (k > 4) bus.wr_data_valid = 1'b0;
          else       bus.wr_data = WIDTH'(k);
        end
      end
      check("wr_all_accepted", k, 5);
    end
    settle(3);
    check("wr_count", wr_addr_q.size() - w0, 4);
    if (wr_addr_q.size() - w0 == 4) begin
      check("wr_addr0", wr_addr_q[w0+0], 4094);
      check("wr_addr1", wr_addr_q[w0+1], 4095);
      check("wr_addr2", wr_addr_q[w0+2], 0);
      check("wr_addr3", wr_addr_q[w0+3], 1);
      for (int i = 0; i < 4; i++) check($sformatf("wr_d%0d", i), wr_d_q[w0+i], i + 1);
      check("wr_done_latency", done_cyc - wr_cyc_q[w0+3], 1);
    end
    check("wr_done_pulses", done_cnt - d0, 1);
    check("wr_no_reads", rd_addr_q.size() - r0, 0);

    // ---- sp_full backpressure during cycles 2-5 of a read burst
    r0 = rd_addr_q.size(); g0 = got_q.size(); d0 = done_cnt; f0 = full_issue_cnt;
    send_cmd(1'b0, 200, 8);
    @(posedge clk); #1;
    bus.sp_full = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.sp_full = 1'b0;
    wait_done("bp_done_seen", 60);
    settle(3);
    check("bp_issue_count", rd_addr_q.size() - r0, 8);
    bad = 0;
    if (rd_addr_q.size() - r0 == 8) begin
      for (int i = 0; i < 8; i++) if (rd_addr_q[r0+i] != 200 + i) bad++;
      check("bp_gap_cycles", rd_cyc_q[r0+1] - rd_cyc_q[r0], 5);
    end
    check("bp_addr_errors", bad, 0);
    check("bp_issue_while_full", full_issue_cnt - f0, 0);
    check("bp_got_count", got_q.size() - g0, 8);
    bad = 0;
    if (got_q.size() - g0 == 8)
      for (int i = 0; i < 8; i++) if (got_q[g0+i] != 200 + i) bad++;
    check("bp_data_errors", bad, 0);
    check("bp_done_pulses", done_cnt - d0, 1);

    // ---- zero-length command
    r0 = rd_addr_q.size(); w0 = wr_addr_q.size(); d0 = done_cnt;
    send_cmd(1'b0, 55, 0);
    @(negedge clk);
    check("zero_done_next_cycle", bus.done, 1);
    check("zero_cmd_ready", bus.cmd_ready, 1);
    settle(4);
    check("zero_done_pulses", done_cnt - d0, 1);
    check("zero_no_reads", rd_addr_q.size() - r0, 0);
    check("zero_no_writes", wr_addr_q.size() - w0, 0);
    check("zero_still_ready", bus.cmd_ready, 1);

    // ---- reset during a read burst with five reads in flight
    g0 = got_q.size(); d0 = done_cnt;
    send_cmd(1'b0, 300, 20);
    repeat (5) @(posedge clk);
    #1;
    check("mid_credits_before_rst", dut.credits, 27);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    check("mid_rst_rd_data_valid", bus.rd_data_valid, 0);
    check("mid_rst_credits", dut.credits, 32);
    check("mid_rst_done", bus.done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    settle(12);
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_no_data", got_q.size() - g0, 0);
    check("mid_rst_idle", bus.cmd_ready, 1);
    g0 = got_q.size(); d0 = done_cnt;
    send_cmd(1'b0, 5, 3);
    wait_done("post_rst_done_seen", 40);
    settle(3);
    check("post_rst_got_count", got_q.size() - g0, 3);
    if (got_q.size() - g0 == 3)
      for (int i = 0; i < 3; i++) check($sformatf("post_rst_data%0d", i), got_q[g0+i], 5 + i);
    check("post_rst_done_pulses", done_cnt - d0, 1);

    // ---- whole-run port invariant
    check("never_rd_and_wr", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
